// File: rtl/word_assembler.sv
// Packs LANE_W-bit lanes little-endian into a WORD_W-bit word and presents it
// with a one-cycle load strobe when full or flushed; partial words are zero-padded.
module word_assembler #(
    parameter int WORD_W = 64,
    parameter int LANE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LANE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [WORD_W-1:0] out_data,
    output logic              out_ld,
    output logic [3:0]        count
);
    localparam int LANES = WORD_W / LANE_W;
    localparam logic [3:0] LAST_LANE = 4'(LANES - 1);

    typedef enum logic {FILL, EMIT} state_t;

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_next;
    logic              accept;
    logic              go_emit;

    // in_ready depends only on state and reset, never on in_valid.
    assign in_ready = rst && (state == FILL);
    assign out_ld   = (state == EMIT);
    assign accept   = in_valid && in_ready;

    assign go_emit = (state == FILL) &&
                     ((accept && (count == LAST_LANE)) ||
                      (flush && ((count != 4'd0) || accept)));

    always_comb begin
        acc_next = acc;
        for (int i = 0; i < LANES; i++) begin
            if (accept && (count == 4'(i))) begin
                acc_next[i*LANE_W +: LANE_W] = in_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (go_emit) state_next = EMIT;
            EMIT:    state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Accumulator lanes above count are always zero, so emitting acc_next pads for free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            count    <= 4'd0;
            out_data <= '0;
        end else if (go_emit) begin
            out_data <= acc_next;
            acc      <= '0;
            count    <= 4'd0;
        end else if (accept) begin
            acc      <= acc_next;
            count    <= count + 4'd1;
        end
    end
endmodule

// File: tb/tb_word_assembler.sv
// Directed bench for word_assembler: a vector table for the steady-state cases
// plus hand sequences for reset, random gaps and reset during a word or strobe.
module tb_word_assembler;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [63:0] out_data;
    logic        out_ld;
    logic [3:0]  count;

    int n_cmp  = 0;
    int n_fail = 0;

    word_assembler #(.WORD_W(64), .LANE_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_data(out_data),
        .out_ld(out_ld), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [7:0]  data;
        logic        flush;
        logic        ld;
        logic [3:0]  cnt;
        logic        rdy;
        logic [63:0] odata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ld, input logic [3:0] cnt,
                           input logic rdy, input logic [63:0] od);
        chk({tag, ".out_ld"},   64'(out_ld),   64'(ld));
        chk({tag, ".count"},    64'(count),    64'(cnt));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
        chk({tag, ".out_data"}, out_data,      od);
    endtask

    function automatic void add(input logic v, input logic [7:0] d, input logic f,
                                input logic ld, input logic [3:0] c, input logic r,
                                input logic [63:0] od);
        vec_t e;
        e.valid = v; e.data = d; e.flush = f; e.ld = ld; e.cnt = c; e.rdy = r; e.odata = od;
        vecs.push_back(e);
    endfunction

    initial begin
        logic [63:0] w1, w2, w3, w4, w5;
        logic [63:0] exp_word;
        int          n_acc;
        int          n_words;
        int          cyc;
        logic        will_acc;

        w1 = 64'h8877665544332211;
        w2 = 64'h0706050403020199;
        w3 = 64'h000000000000BBAA;
        w4 = 64'h0000000000CCBBAA;
        w5 = 64'h0807060504030201;

        // Full word, held lane across the bubble, second word 9 cycles later
        for (int j = 0; j < 7; j++) add(1, 8'(8'h11 * (j + 1)), 0, 0, 4'(j + 1), 1, 64'h0);
        add(1, 8'h88, 0, 1, 0, 0, w1);
        add(1, 8'h99, 0, 0, 0, 1, w1);
        add(1, 8'h99, 0, 0, 1, 1, w1);
        for (int j = 1; j < 7; j++) add(1, 8'(j), 0, 0, 4'(j + 1), 1, w1);
        add(1, 8'h07, 0, 1, 0, 0, w2);
        add(0, 8'h00, 0, 0, 0, 1, w2);
        // Partial flush, flush during EMIT, flush on empty
        add(1, 8'hAA, 0, 0, 1, 1, w2);
        add(1, 8'hBB, 0, 0, 2, 1, w2);
        add(0, 8'h00, 1, 1, 0, 0, w3);
        add(0, 8'h00, 1, 0, 0, 1, w3);
        add(0, 8'h00, 1, 0, 0, 1, w3);
        // Flush together with a lane
        add(1, 8'hAA, 0, 0, 1, 1, w3);
        add(1, 8'hBB, 0, 0, 2, 1, w3);
        add(1, 8'hCC, 1, 1, 0, 0, w4);
        add(0, 8'h00, 0, 0, 0, 1, w4);
        // Flush together with the 8th lane gives one strobe
        for (int j = 1; j < 8; j++) add(1, 8'(j), 0, 0, 4'(j), 1, w4);
        add(1, 8'h08, 1, 1, 0, 0, w5);
        add(0, 8'h00, 0, 0, 0, 1, w5);
        // Gapped input then flush
        add(1, 8'h55, 0, 0, 1, 1, w5);
        add(0, 8'h00, 0, 0, 1, 1, w5);
        add(1, 8'h66, 0, 0, 2, 1, w5);
        add(0, 8'h00, 1, 1, 0, 0, 64'h0000000000006655);

        // Reset held for 3 cycles with in_valid asserted
        rst = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("reset%0d", i), 0, 0, 0, 64'h0);
        end
        rst = 1'b1;
        step();
        chk("first_accept.count", 64'(count), 64'd1);
        #2 rst = 1'b0;
        #1 chk_all("reset_again", 0, 0, 0, 64'h0);
        step();
        rst = 1'b1; in_valid = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid = vecs[i].valid;
            in_data  = vecs[i].data;
            flush    = vecs[i].flush;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].ld, vecs[i].cnt, vecs[i].rdy, vecs[i].odata);
        end
        flush = 1'b0;

        // Random valid gaps: 16 lanes must form exactly two words
        n_acc = 0; n_words = 0; cyc = 0;
        in_data = 8'h30;
        while ((n_acc < 16 || n_words < 2) && cyc < 300) begin
            in_valid = (n_acc < 16) ? 1'($urandom_range(0, 1)) : 1'b0;
            will_acc = in_valid && in_ready;
            step();
            cyc++;
            if (will_acc) begin
                n_acc++;
                in_data = 8'(8'h30 + n_acc);
            end
            chk("gap.count", 64'(count), 64'(n_acc % 8));
            if (out_ld) begin
                for (int j = 0; j < 8; j++) exp_word[8*j +: 8] = 8'(8'h30 + 8 * n_words + j);
                chk("gap.word", out_data, exp_word);
                n_words++;
            end
        end
        chk("gap.words_seen", 64'(n_words), 64'd2);
        in_valid = 1'b0;
        step();

        // Reset after 5 lanes discards them
        for (int j = 0; j < 5; j++) begin
            in_valid = 1'b1; in_data = 8'(8'hE1 + j);
            step();
        end
        chk("mid5.count", 64'(count), 64'd5);
        #2 rst = 1'b0;
        #1 chk_all("mid_reset", 0, 0, 0, 64'h0);
        step();
        chk_all("mid_reset_edge", 0, 0, 0, 64'h0);
        rst = 1'b1;
        for (int j = 0; j < 8; j++) begin
            in_valid = 1'b1; in_data = 8'(8'hF0 + j);
            step();
        end
        in_valid = 1'b0;
        chk_all("after_reset_word", 1, 0, 0, 64'hF7F6F5F4F3F2F1F0);

        // Reset during EMIT drops the strobe at once
        #2 rst = 1'b0;
        #1 chk_all("emit_reset", 0, 0, 0, 64'h0);
        step();
        rst = 1'b1;
        step();
        chk_all("post_reset_idle", 0, 0, 1, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
